traffic_phase_sequencer: RTL and testbench



---
 rtl/traffic_pkg.sv | 64 ++++++
 rtl/traffic_phase_sequencer_prescaler.sv | 37 +++
 rtl/traffic_phase_sequencer.sv | 99 +++++++++
 tb/tb_traffic_phase_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types and helpers for the two-road traffic-light phase sequencer.
//   phase_t      : phase encoding (also driven on the debug 'phase' output)
//   bcd_dur_t    : packed two-digit BCD duration {ten, unit}, legal 01..99
//   lamps_t      : NS/EW lamp pair, each {red, yellow, green} one-hot
//   next_phase   : cycle order NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> NS_G
//   phase_lamps  : lamp pattern shown in a given phase
//   phase_legal  : false for the one unused encoding
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        NS_G = 3'd1,
        NS_Y = 3'd2,
        AR1  = 3'd3,
        EW_G = 3'd4,
        EW_Y = 3'd5,
        AR2  = 3'd6
    } phase_t;

    typedef logic [7:0] bcd_dur_t;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
    } lamps_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // INIT leaves on the first tick into NS_G; an unused encoding maps to
    // INIT so the caller never loads a bogus phase.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            INIT:    return NS_G;
            NS_G:    return NS_Y;
            NS_Y:    return AR1;
            AR1:     return EW_G;
            EW_G:    return EW_Y;
            EW_Y:    return AR2;
            AR2:     return NS_G;
            default: return INIT;
        endcase
    endfunction

    // Every pattern keeps at least one road on red.
    function automatic lamps_t phase_lamps(input phase_t p);
        case (p)
            NS_G:    return '{ns: LAMP_G, ew: LAMP_R};
            NS_Y:    return '{ns: LAMP_Y, ew: LAMP_R};
            EW_G:    return '{ns: LAMP_R, ew: LAMP_G};
            EW_Y:    return '{ns: LAMP_R, ew: LAMP_Y};
            default: return '{ns: LAMP_R, ew: LAMP_R};
        endcase
    endfunction

    function automatic logic phase_legal(input logic [2:0] p);
        return p != 3'd7;
    endfunction

endpackage

// File: rtl/traffic_phase_sequencer_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a one-cycle tick every TICK_DIV cycles of run=1.
// The count freezes while run=0 and resumes from the held value, so pausing
// never shortens or lengthens the interval between ticks.
//   clk     : system clock
//   reset_n : asynchronous active-low reset (count -> 0)
//   run     : count enable
//   tick    : high for the single cycle where count == TICK_DIV-1 and run=1
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50000000   // >= 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = run && (count == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset_n) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// traffic_phase_sequencer
// Master-side controller for a two-digit BCD countdown counter. Issues the
// counter's enable tick, supplies its reload value, and steps a two-road
// traffic-light cycle each time the counter expires.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset (INIT, both roads red)
//   run        : 1 = advance, 0 = freeze (no ticks, state held)
//   cnt_done   : counter shows 01
//   cnt_enable : one-clk tick to the counter enable
//   val_ten    : reload tens digit
//   val_unit   : reload units digit
//   ns_lamp    : north-south {red,yellow,green}
//   ew_lamp    : east-west {red,yellow,green}
//   phase      : current phase encoding
// -----------------------------------------------------------------------------
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter bcd_dur_t    NS_GRN_T = 8'h25,
    parameter bcd_dur_t    NS_YEL_T = 8'h03,
    parameter bcd_dur_t    EW_GRN_T = 8'h20,
    parameter bcd_dur_t    EW_YEL_T = 8'h03,
    parameter bcd_dur_t    ALLRED_T = 8'h02
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       cnt_done,
    output logic       cnt_enable,
    output logic [3:0] val_ten,
    output logic [3:0] val_unit,
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp,
    output logic [2:0] phase
);

    phase_t   state;
    phase_t   nxt;
    lamps_t   lamps_next;
    bcd_dur_t reload;
    logic     advance;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .tick    (cnt_enable)
    );

    assign nxt        = next_phase(state);
    assign lamps_next = phase_lamps(nxt);

    // The counter starts blank, so INIT leaves on the first tick alone; every
    // other phase leaves on the tick that finds the counter at 01, which is
    // the same edge on which the counter reloads.
    assign advance = cnt_enable & ((state == INIT) | cnt_done);

    // Offer the length of the phase we are about to enter, so the counter
    // picks up the new duration exactly at the boundary. In INIT this is the
    // NS green length, consumed by the counter's first load.
    always_comb begin
        // NOTE: assign a default before the case so no path leaves reload
        // unassigned, which would infer a latch.
        reload = NS_GRN_T;
        case (nxt)
            NS_Y:     reload = NS_YEL_T;
            AR1, AR2: reload = ALLRED_T;
            EW_G:     reload = EW_GRN_T;
            EW_Y:     reload = EW_YEL_T;
            default:  reload = NS_GRN_T;
        endcase
    end

    assign val_ten  = reload[7:4];
    assign val_unit = reload[3:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= INIT;
            ns_lamp <= LAMP_R;
            ew_lamp <= LAMP_R;
        end else if (!phase_legal(state)) begin
            state   <= INIT;
            ns_lamp <= LAMP_R;
            ew_lamp <= LAMP_R;
        end else if (advance) begin
            state   <= nxt;
            ns_lamp <= lamps_next.ns;
            ew_lamp <= lamps_next.ew;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_sequencer
// Drives traffic_phase_sequencer against a behavioural two-digit BCD countdown
// counter. Expected phase transitions are queued when stimulus is applied and
// compared as the DUT changes phase. Lamp safety is checked every clock.
// -----------------------------------------------------------------------------
module tb_traffic_phase_sequencer;

    localparam logic [2:0] P_INIT = 3'd0, P_NSG = 3'd1, P_NSY = 3'd2, P_AR1 = 3'd3,
                           P_EWG  = 3'd4, P_EWY = 3'd5, P_AR2 = 3'd6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       run = 1'b0;
    logic       force_done = 1'b0;
    logic       cnt_done;
    logic       cnt_enable;
    logic [3:0] val_ten;
    logic [3:0] val_unit;
    logic [2:0] ns_lamp;
    logic [2:0] ew_lamp;
    logic [2:0] phase;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    traffic_phase_sequencer #(
        .TICK_DIV (4),
        .NS_GRN_T (8'h05),
        .NS_YEL_T (8'h02),
        .EW_GRN_T (8'h04),
        .EW_YEL_T (8'h02),
        .ALLRED_T (8'h01)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .cnt_done   (cnt_done),
        .cnt_enable (cnt_enable),
        .val_ten    (val_ten),
        .val_unit   (val_unit),
        .ns_lamp    (ns_lamp),
        .ew_lamp    (ew_lamp),
        .phase      (phase)
    );

    // ---------------- behavioural countdown counter ----------------
    logic [7:0] cnt_q;
    logic       blank;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'h00;
            blank <= 1'b1;
        end else if (cnt_enable) begin
            if (blank || cnt_q == 8'h01) begin
                cnt_q <= {val_ten, val_unit};
                blank <= 1'b0;
            end else if (cnt_q[3:0] == 4'd0) begin
                cnt_q <= {cnt_q[7:4] - 4'd1, 4'd9};
            end else begin
                cnt_q <= {cnt_q[7:4], cnt_q[3:0] - 4'd1};
            end
        end
    end

    assign cnt_done = (!blank && cnt_q == 8'h01) || force_done;

    // ---------------- reference tables ----------------
    function automatic logic [7:0] exp_dur(input logic [2:0] p);
        case (p)
            P_NSY:        return 8'h02;
            P_AR1, P_AR2: return 8'h01;
            P_EWG:        return 8'h04;
            P_EWY:        return 8'h02;
            default:      return 8'h05;
        endcase
    endfunction

    function automatic logic [2:0] exp_next(input logic [2:0] p);
        return (p == P_AR2 || p == P_INIT) ? P_NSG : p + 3'd1;
    endfunction

    function automatic logic [2:0] exp_ns(input logic [2:0] p);
        return (p == P_NSG) ? 3'b001 : (p == P_NSY) ? 3'b010 : 3'b100;
    endfunction

    function automatic logic [2:0] exp_ew(input logic [2:0] p);
        return (p == P_EWG) ? 3'b001 : (p == P_EWY) ? 3'b010 : 3'b100;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [2:0] ph;
        int         dwell_prev;   // ticks spent in the phase being left
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input logic [2:0] ph, input int dwell_prev);
        exp_t e;
        e.ph = ph;
        e.dwell_prev = dwell_prev;
        sb.push_back(e);
    endtask

    // One clock, landing on the falling edge, with the lamp safety invariant.
    task automatic step();
        @(negedge clk);
        n_cmp++;
        if (!($onehot(ns_lamp) && $onehot(ew_lamp) && (ns_lamp == 3'b100 || ew_lamp == 3'b100))) begin
            n_bad++;
            $display("FAIL lamp_safety: ns=%b ew=%b, required one-hot with at least one red", ns_lamp, ew_lamp);
        end
    endtask

    task automatic wait_change(input int budget, output int ticks, output int cycles,
                               output bit td, output bit ok);
        logic [2:0] start;
        start  = phase;
        ticks  = 0;
        cycles = 0;
        td     = 1'b0;
        ok     = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cnt_enable) ticks++;
            td = cnt_enable & cnt_done;
            step();
            cycles++;
            if (phase !== start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: phase stuck at %0d for %0d clks, required a change", start, budget);
        end
    endtask

    task automatic drain_scoreboard();
        exp_t e;
        int   t, c;
        bit   td, ok;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_change(200, t, c, td, ok);
            if (!ok) continue;
            n_cmp++;
            if (phase !== e.ph) begin
                n_bad++; $display("FAIL sb_phase: got %0d, required %0d", phase, e.ph);
            end
            n_cmp++;
            if ({ns_lamp, ew_lamp} !== {exp_ns(e.ph), exp_ew(e.ph)}) begin
                n_bad++; $display("FAIL sb_lamps phase %0d: got ns=%b ew=%b, required ns=%b ew=%b",
                                  e.ph, ns_lamp, ew_lamp, exp_ns(e.ph), exp_ew(e.ph));
            end
            n_cmp++;
            if (t != e.dwell_prev) begin
                n_bad++; $display("FAIL sb_dwell into %0d: got %0d ticks, required %0d", e.ph, t, e.dwell_prev);
            end
            n_cmp++;
            if (!td) begin
                n_bad++; $display("FAIL sb_edge into %0d: got enable&done=0, required 1", e.ph);
            end
            n_cmp++;
            if (cnt_q !== exp_dur(e.ph)) begin
                n_bad++; $display("FAIL sb_load into %0d: counter got %h, required %h", e.ph, cnt_q, exp_dur(e.ph));
            end
            n_cmp++;
            if ({val_ten, val_unit} !== exp_dur(exp_next(e.ph))) begin
                n_bad++; $display("FAIL sb_val in %0d: got %h, required %h", e.ph, {val_ten, val_unit},
                                  exp_dur(exp_next(e.ph)));
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        run     = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        n_cmp++;
        if (phase !== P_INIT) begin n_bad++; $display("FAIL reset_phase: got %0d, required 0", phase); end
        n_cmp++;
        if ({ns_lamp, ew_lamp} !== 6'b100_100) begin
            n_bad++; $display("FAIL reset_lamps: got ns=%b ew=%b, required 100/100", ns_lamp, ew_lamp);
        end
        n_cmp++;
        if (cnt_enable !== 1'b0) begin n_bad++; $display("FAIL reset_enable: got %b, required 0", cnt_enable); end
        n_cmp++;
        if ({val_ten, val_unit} !== 8'h05) begin
            n_bad++; $display("FAIL reset_val: got %h, required 05", {val_ten, val_unit});
        end
    endtask

    // From a reset/idle INIT with prescaler at 0: run=1 gives NS_G on clk 4.
    task automatic test_first_tick(input string tag);
        int t, c;
        bit td, ok;
        run = 1'b1;
        wait_change(20, t, c, td, ok);
        n_cmp++;
        if (c != 4 || t != 1) begin
            n_bad++; $display("FAIL %s_latency: got %0d clks/%0d ticks, required 4/1", tag, c, t);
        end
        n_cmp++;
        if (phase !== P_NSG || {ns_lamp, ew_lamp} !== 6'b001_100) begin
            n_bad++; $display("FAIL %s_state: got phase=%0d ns=%b ew=%b, required 1 001 100", tag, phase, ns_lamp, ew_lamp);
        end
        n_cmp++;
        if (cnt_q !== 8'h05) begin n_bad++; $display("FAIL %s_load: got %h, required 05", tag, cnt_q); end
        n_cmp++;
        if ({val_ten, val_unit} !== 8'h02) begin
            n_bad++; $display("FAIL %s_val: got %h, required 02", tag, {val_ten, val_unit});
        end
    endtask

    task automatic test_full_cycle();
        push_exp(P_NSY, 5);
        push_exp(P_AR1, 2);
        push_exp(P_EWG, 1);
        push_exp(P_EWY, 4);
        push_exp(P_AR2, 2);
        push_exp(P_NSG, 1);
        drain_scoreboard();
    endtask

    // Pause two clocks after the first NS_G tick (prescaler holding at 1).
    task automatic test_run_pause();
        int t, c, seen;
        bit td, ok;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cnt_enable) break;
        end
        n_cmp++;
        if (cnt_enable !== 1'b1) begin n_bad++; $display("FAIL pause_find_tick: got %b, required 1", cnt_enable); end
        step();
        step();
        run  = 1'b0;
        seen = 0;
        repeat (20) begin
            step();
            if (cnt_enable) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_bad++; $display("FAIL pause_ticks: got %0d, required 0", seen); end
        n_cmp++;
        if (phase !== P_NSG || {ns_lamp, ew_lamp} !== 6'b001_100) begin
            n_bad++; $display("FAIL pause_hold: got phase=%0d ns=%b ew=%b, required 1 001 100", phase, ns_lamp, ew_lamp);
        end
        n_cmp++;
        if (cnt_q !== 8'h04) begin n_bad++; $display("FAIL pause_counter: got %h, required 04", cnt_q); end
        run = 1'b1;
        c = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            c++;
            if (cnt_enable) break;
        end
        n_cmp++;
        if (c != 2) begin n_bad++; $display("FAIL pause_resume_spacing: got %0d clks, required 2", c); end
        wait_change(100, t, c, td, ok);
        n_cmp++;
        if (t != 4 || phase !== P_NSY || cnt_q !== 8'h02) begin
            n_bad++; $display("FAIL pause_remaining: got %0d ticks phase=%0d cnt=%h, required 4 2 02", t, phase, cnt_q);
        end
    endtask

    task automatic test_async_reset();
        push_exp(P_AR1, 2);
        push_exp(P_EWG, 1);
        push_exp(P_EWY, 4);
        drain_scoreboard();
        step();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (phase !== P_INIT || {ns_lamp, ew_lamp} !== 6'b100_100) begin
            n_bad++; $display("FAIL areset_immediate: got phase=%0d ns=%b ew=%b, required 0 100 100", phase, ns_lamp, ew_lamp);
        end
        step();
        step();
        reset_n = 1'b1;
        test_first_tick("areset_restart");
    endtask

    // cnt_done forced high between ticks must not move the state.
    task automatic test_force_done();
        int t, c;
        bit td, ok;
        force_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (phase !== P_NSG) begin
                n_bad++; $display("FAIL force_done_hold clk %0d: got phase=%0d, required 1", i, phase);
            end
        end
        n_cmp++;
        if (cnt_enable !== 1'b1) begin n_bad++; $display("FAIL force_done_tick: got %b, required 1", cnt_enable); end
        force_done = 1'b0;
        push_exp(P_NSY, 5);
        push_exp(P_AR1, 2);
        drain_scoreboard();
        n_cmp++;
        if (cnt_done !== 1'b1) begin n_bad++; $display("FAIL one_tick_done: got %b, required 1", cnt_done); end
        wait_change(100, t, c, td, ok);
        n_cmp++;
        if (t != 1 || phase !== P_EWG || !td) begin
            n_bad++; $display("FAIL one_tick_dwell: got %0d ticks phase=%0d edge=%b, required 1 4 1", t, phase, td);
        end
        push_exp(P_EWY, 4);
        push_exp(P_AR2, 2);
        push_exp(P_NSG, 1);
        drain_scoreboard();
    endtask

    initial begin
        test_reset();
        test_first_tick("first_tick");
        test_full_cycle();
        test_run_pause();
        test_async_reset();
        test_force_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
